// File: rtl/bootrom_shadow_pkg.sv
// -----------------------------------------------------------------------------
// bootrom_shadow_pkg
// Shared constants for the boot ROM shadow copier:
//   - state encoding (IDLE, RD, WR, DONE, and VRD/VCMP for the verify build)
//   - default base addresses and copy length
//   - word_addr(): 19-bit modulo word address generation (wraps silently)
// -----------------------------------------------------------------------------
package bootrom_shadow_pkg;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] VRD  = 3'd4;
    localparam logic [2:0] VCMP = 3'd5;

    localparam logic [18:0] DEF_SRC_BASE = 19'h7FF00;
    localparam logic [18:0] DEF_DST_BASE = 19'h7FF00;
    localparam int          DEF_WORDS    = 256;

    // Widest possible word counter (WORDS = 65536 needs 17 bits).
    localparam int OFFSET_W = 17;

    // base + offset in 19 bits; carries out of bit 18 are dropped so the
    // address wraps above 19'h7FFFF.
    function automatic logic [18:0] word_addr(input logic [18:0]         base,
                                              input logic [OFFSET_W-1:0] offset);
        return base + {2'b00, offset};
    endfunction

endpackage

// File: rtl/bootrom_shadow_wb_master_port.sv
// -----------------------------------------------------------------------------
// bootrom_shadow_wb_master_port
// Single-beat Wishbone master handshake, used once for the ROM (source) side
// and once for the RAM (destination) side.
//
// Handshake: cyc/stb act as "valid" and ack as "ready". While active is high
// the port holds cyc=stb=1 (and we=write) for as many wait states as the slave
// needs. A beat completes on the clock edge where stb and ack are both high;
// beat_o flags that cycle so the sequencer can advance, which deasserts
// active and therefore drops cyc/stb in the cycle after the ack. Acks that
// arrive while the port is idle never produce a beat.
//
// Ports:
//   active  in  : owning state is current
//   write   in  : beat is a write
//   ack_i   in  : slave acknowledge (may be combinational with stb)
//   cyc_o   out : Wishbone cycle
//   stb_o   out : Wishbone strobe
//   we_o    out : Wishbone write enable
//   beat_o  out : beat completes at the next clock edge
// -----------------------------------------------------------------------------
module bootrom_shadow_wb_master_port (
    input  logic active,
    input  logic write,
    input  logic ack_i,
    output logic cyc_o,
    output logic stb_o,
    output logic we_o,
    output logic beat_o
);

    assign cyc_o  = active;
    assign stb_o  = active;
    assign we_o   = active & write;
    assign beat_o = active & ack_i;

endmodule

// File: rtl/bootrom_shadow.sv
// -----------------------------------------------------------------------------
// bootrom_shadow
// Boot-time sequencer: copies WORDS 16-bit words from the boot ROM (source
// Wishbone port) into shadow RAM (destination Wishbone port) and holds the CPU
// in reset-hold until the copy has finished.
//
// Optional build macro: BOOTSHADOW_VERIFY_EN
//   Adds a read-back (VRD) and compare (VCMP) step after every write, the
//   d_dat_i read-data port and a sticky verify_err_o flag.
//
// Ports:
//   clk, rst           : clock, asynchronous active-low reset
//   start_i            : (re)copy request, honoured in IDLE or DONE only
//   busy_o             : copy in progress
//   done_o             : copy finished (DONE state)
//   cpu_hold_o         : CPU reset-hold, released on reaching DONE
//   s_*                : ROM read port (we tied 0, sel tied 2'b11)
//   d_*                : RAM write port (sel tied 2'b11)
//   d_dat_i            : RAM read-back data (verify build only)
//   verify_err_o       : sticky read-back mismatch (verify build only)
//   dbg_state_o        : current FSM state
// -----------------------------------------------------------------------------
module bootrom_shadow
    import bootrom_shadow_pkg::*;
#(
    parameter logic [18:0] SRC_BASE   = DEF_SRC_BASE,
    parameter logic [18:0] DST_BASE   = DEF_DST_BASE,
    parameter int          WORDS      = DEF_WORDS,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        cpu_hold_o,
    output logic [19:1] s_adr_o,
    input  logic [15:0] s_dat_i,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [1:0]  s_sel_o,
    input  logic        s_ack_i,
    output logic [19:1] d_adr_o,
    output logic [15:0] d_dat_o,
    output logic        d_cyc_o,
    output logic        d_stb_o,
    output logic        d_we_o,
    output logic [1:0]  d_sel_o,
    input  logic        d_ack_i,
`ifdef BOOTSHADOW_VERIFY_EN
    input  logic [15:0] d_dat_i,
    output logic        verify_err_o,
`endif
    output logic [2:0]  dbg_state_o
);

    localparam int            CW       = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

    logic [2:0]    state_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   dat_q;
    logic          first_q;   // set by reset, cleared by the first clock after it
    logic          last_word;
    logic          s_beat;
    logic          d_beat;
    logic          src_active;
    logic          dst_active;
`ifdef BOOTSHADOW_VERIFY_EN
    logic [15:0]   rb_q;
    logic          err_q;
`endif

    assign last_word = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dat_q   <= '0;
            first_q <= 1'b1;
`ifdef BOOTSHADOW_VERIFY_EN
            rb_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            first_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if ((AUTO_START && first_q) || start_i) begin
                        state_q <= RD;
`ifdef BOOTSHADOW_VERIFY_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                RD: begin
                    if (s_beat) begin
                        dat_q   <= s_dat_i;
                        state_q <= WR;
                    end
                end
                WR: begin
                    if (d_beat) begin
`ifdef BOOTSHADOW_VERIFY_EN
                        state_q <= VRD;
`else
                        if (last_word) begin
                            state_q <= DONE;
                        end else begin
                            cnt_q   <= cnt_q + CW'(1);
                            state_q <= RD;
                        end
`endif
                    end
                end
`ifdef BOOTSHADOW_VERIFY_EN
                VRD: begin
                    if (d_beat) begin
                        rb_q    <= d_dat_i;
                        state_q <= VCMP;
                    end
                end
                VCMP: begin
                    // A mismatch is only recorded; the copy carries on.
                    if (rb_q != dat_q) begin
                        err_q <= 1'b1;
                    end
                    if (last_word) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        state_q <= RD;
                    end
                end
`endif
                DONE: begin
                    if (start_i) begin
                        cnt_q   <= '0;
                        state_q <= RD;
`ifdef BOOTSHADOW_VERIFY_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Port ownership follows the state, so only one port can ever be active
    // and a reset drops both strobes without waiting for a clock.
    assign src_active = (state_q == RD);
`ifdef BOOTSHADOW_VERIFY_EN
    assign dst_active = (state_q == WR) || (state_q == VRD);
    assign busy_o     = (state_q == RD) || (state_q == WR) ||
                        (state_q == VRD) || (state_q == VCMP);
    assign verify_err_o = err_q;
`else
    assign dst_active = (state_q == WR);
    assign busy_o     = (state_q == RD) || (state_q == WR);
`endif

    assign done_o      = (state_q == DONE);
    assign cpu_hold_o  = (state_q != DONE);
    assign dbg_state_o = state_q;

    assign s_adr_o = word_addr(SRC_BASE, OFFSET_W'(cnt_q));
    assign d_adr_o = word_addr(DST_BASE, OFFSET_W'(cnt_q));
    assign d_dat_o = dat_q;
    assign s_sel_o = 2'b11;
    assign d_sel_o = 2'b11;

    bootrom_shadow_wb_master_port u_src_port (
        .active (src_active),
        .write  (1'b0),
        .ack_i  (s_ack_i),
        .cyc_o  (s_cyc_o),
        .stb_o  (s_stb_o),
        .we_o   (s_we_o),
        .beat_o (s_beat)
    );

    bootrom_shadow_wb_master_port u_dst_port (
        .active (dst_active),
        .write  (state_q == WR),
        .ack_i  (d_ack_i),
        .cyc_o  (d_cyc_o),
        .stb_o  (d_stb_o),
        .we_o   (d_we_o),
        .beat_o (d_beat)
    );

endmodule

// File: tb/tb_bootrom_shadow.sv
// -----------------------------------------------------------------------------
// tb_bootrom_shadow
// Main instance: 256 words, AUTO_START=1, ROM word = addr ^ 16'hA5A5, RAM kept
// in an associative array, random wait states on both slaves.
// Small instance: WORDS=1, SRC_BASE=19'h7FFFF, DST_BASE=0, AUTO_START=0.
// -----------------------------------------------------------------------------
module tb_bootrom_shadow;

`ifdef BOOTSHADOW_VERIFY_EN
    localparam int CPW = 4;
`else
    localparam int CPW = 2;
`endif
    localparam logic [18:0] M_SRC   = 19'h7FF00;
    localparam logic [18:0] M_DST   = 19'h01000;
    localparam int          M_WORDS = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT signals ----------------
    logic        m_start;
    logic        m_busy_o, m_done_o, m_cpu_hold_o;
    logic [19:1] m_s_adr_o, m_d_adr_o;
    logic [15:0] m_s_dat_i, m_d_dat_o;
    logic        m_s_cyc_o, m_s_stb_o, m_s_we_o, m_s_ack_i;
    logic        m_d_cyc_o, m_d_stb_o, m_d_we_o, m_d_ack_i;
    logic [1:0]  m_s_sel_o, m_d_sel_o;
    logic [2:0]  m_dbg_state;
`ifdef BOOTSHADOW_VERIFY_EN
    logic [15:0] m_d_dat_i;
    logic        m_verify_err_o;
`endif

    // ---------------- small DUT signals ----------------
    logic        w_start;
    logic        w_busy_o, w_done_o, w_cpu_hold_o;
    logic [19:1] w_s_adr_o, w_d_adr_o;
    logic [15:0] w_s_dat_i, w_d_dat_o;
    logic        w_s_cyc_o, w_s_stb_o, w_s_we_o, w_s_ack_i;
    logic        w_d_cyc_o, w_d_stb_o, w_d_we_o, w_d_ack_i;
    logic [1:0]  w_s_sel_o, w_d_sel_o;
    logic [2:0]  w_dbg_state;
`ifdef BOOTSHADOW_VERIFY_EN
    logic [15:0] w_d_dat_i;
    logic        w_verify_err_o;
    assign w_d_dat_i = 16'h5A5A;
`endif

    bootrom_shadow #(
        .SRC_BASE(M_SRC), .DST_BASE(M_DST), .WORDS(M_WORDS), .AUTO_START(1'b1)
    ) u_main (
        .clk(clk), .rst(rst), .start_i(m_start),
        .busy_o(m_busy_o), .done_o(m_done_o), .cpu_hold_o(m_cpu_hold_o),
        .s_adr_o(m_s_adr_o), .s_dat_i(m_s_dat_i), .s_cyc_o(m_s_cyc_o),
        .s_stb_o(m_s_stb_o), .s_we_o(m_s_we_o), .s_sel_o(m_s_sel_o), .s_ack_i(m_s_ack_i),
        .d_adr_o(m_d_adr_o), .d_dat_o(m_d_dat_o), .d_cyc_o(m_d_cyc_o),
        .d_stb_o(m_d_stb_o), .d_we_o(m_d_we_o), .d_sel_o(m_d_sel_o), .d_ack_i(m_d_ack_i),
`ifdef BOOTSHADOW_VERIFY_EN
        .d_dat_i(m_d_dat_i), .verify_err_o(m_verify_err_o),
`endif
        .dbg_state_o(m_dbg_state)
    );

    bootrom_shadow #(
        .SRC_BASE(19'h7FFFF), .DST_BASE(19'h00000), .WORDS(1), .AUTO_START(1'b0)
    ) u_small (
        .clk(clk), .rst(rst), .start_i(w_start),
        .busy_o(w_busy_o), .done_o(w_done_o), .cpu_hold_o(w_cpu_hold_o),
        .s_adr_o(w_s_adr_o), .s_dat_i(w_s_dat_i), .s_cyc_o(w_s_cyc_o),
        .s_stb_o(w_s_stb_o), .s_we_o(w_s_we_o), .s_sel_o(w_s_sel_o), .s_ack_i(w_s_ack_i),
        .d_adr_o(w_d_adr_o), .d_dat_o(w_d_dat_o), .d_cyc_o(w_d_cyc_o),
        .d_stb_o(w_d_stb_o), .d_we_o(w_d_we_o), .d_sel_o(w_d_sel_o), .d_ack_i(w_d_ack_i),
`ifdef BOOTSHADOW_VERIFY_EN
        .d_dat_i(w_d_dat_i), .verify_err_o(w_verify_err_o),
`endif
        .dbg_state_o(w_dbg_state)
    );

    // ---------------- slave models ----------------
    // ROM: combinational data; ack after a random number of wait states.
    int max_wait = 0;
    int s_wcnt = 0, s_wtgt = 0, d_wcnt = 0, d_wtgt = 0;
    logic corrupt_en = 1'b0;
    logic [15:0] ram [logic [18:0]];
    int m_wr_cnt = 0;

    assign m_s_dat_i = m_s_adr_o[16:1] ^ 16'hA5A5;
    assign m_s_ack_i = m_s_stb_o && (s_wcnt == s_wtgt);
    assign m_d_ack_i = m_d_stb_o && (d_wcnt == d_wtgt);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_wcnt <= 0; s_wtgt <= 0; d_wcnt <= 0; d_wtgt <= 0;
        end else begin
            if (m_s_stb_o) begin
                if (m_s_ack_i) begin
                    s_wcnt <= 0;
                    s_wtgt <= int'($urandom_range(max_wait));
                end else s_wcnt <= s_wcnt + 1;
            end
            if (m_d_stb_o) begin
                if (m_d_ack_i) begin
                    d_wcnt <= 0;
                    d_wtgt <= int'($urandom_range(max_wait));
                end else d_wcnt <= d_wcnt + 1;
            end
        end
    end

    // RAM write capture.
    always @(posedge clk) begin
        if (rst && m_d_stb_o && m_d_we_o && m_d_ack_i) begin
            ram[m_d_adr_o] = m_d_dat_o;
            m_wr_cnt = m_wr_cnt + 1;
        end
    end

`ifdef BOOTSHADOW_VERIFY_EN
    // RAM read-back, optionally corrupting word 5.
    always @(negedge clk) begin
        if (ram.exists(m_d_adr_o)) m_d_dat_i = ram[m_d_adr_o];
        else m_d_dat_i = 16'h0000;
        if (corrupt_en && (m_d_adr_o == M_DST + 19'd5)) m_d_dat_i = m_d_dat_i ^ 16'h0100;
    end
`endif

    // Small instance slaves: zero-wait, combinational ack.
    assign w_s_dat_i = w_s_adr_o[16:1] ^ 16'hA5A5;
    assign w_s_ack_i = w_s_stb_o;
    assign w_d_ack_i = w_d_stb_o;

    // ---------------- protocol monitors ----------------
    int   stb_viol = 0, both_viol = 0, hold_bad = 0;
    logic s_pend = 1'b0, d_pend = 1'b0;
    always @(posedge clk) begin
        s_pend <= rst && m_s_stb_o && !m_s_ack_i;
        d_pend <= rst && m_d_stb_o && !m_d_ack_i;
    end
    always @(negedge clk) begin
        if (rst) begin
            if (s_pend && !m_s_stb_o) stb_viol++;
            if (d_pend && !m_d_stb_o) stb_viol++;
            if (m_s_stb_o && m_d_stb_o) both_viol++;
            if (m_cpu_hold_o === m_done_o) hold_bad++;
        end
    end

    // ---------------- checking ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: RAM word i must equal ROM word i for the whole image.
    function automatic int ram_bad();
        int bad = 0;
        for (int i = 0; i < M_WORDS; i++) begin
            logic [18:0] da, sa;
            da = M_DST + 19'(i);
            sa = M_SRC + 19'(i);
            if (!ram.exists(da)) bad++;
            else if (ram[da] !== (sa[15:0] ^ 16'hA5A5)) bad++;
        end
        return bad;
    endfunction

    task automatic run_to_done(input int budget, output int took);
        took = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (m_done_o) begin
                took = k + 1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) m_start = 1'b1;
        @(negedge clk) m_start = 1'b0;
    endtask

    int  t0, t1, took;
    bit  pulsed, found;

    initial begin
        rst = 1'b0; m_start = 1'b0; w_start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_state", 32'(m_dbg_state), 32'(0));
        chk("rst_busy_done_hold", 32'({m_busy_o, m_done_o, m_cpu_hold_o}), 32'b001);
        chk("rst_strobes", 32'({m_s_cyc_o, m_s_stb_o, m_s_we_o, m_d_cyc_o, m_d_stb_o, m_d_we_o}), 32'(0));
        chk("rst_src_adr", 32'(m_s_adr_o), 32'(M_SRC));
        chk("rst_dst_adr", 32'(m_d_adr_o), 32'(M_DST));
        chk("rst_dat_sel", 32'({m_d_dat_o, m_s_sel_o, m_d_sel_o}), 32'h0000F);
        chk("w_rst_src_adr", 32'(w_s_adr_o), 32'h7FFFF);
        chk("w_rst_dst_adr", 32'(w_d_adr_o), 32'(0));
`ifdef BOOTSHADOW_VERIFY_EN
        chk("rst_verify_err", 32'(m_verify_err_o), 32'(0));
`endif

        // Copy 1: zero-wait auto start, start_i pulsed at word 100 is ignored
        #2 rst = 1'b1;
        @(negedge clk);
        chk("auto_start_rd", 32'({m_s_cyc_o, m_s_stb_o, m_d_stb_o, m_cpu_hold_o}), 32'b1101);
        chk("auto_start_adr", 32'(m_s_adr_o), 32'(M_SRC));
        t0 = cyc; t1 = -1; pulsed = 1'b0;
        for (int k = 0; k < M_WORDS * CPW + 20; k++) begin
            @(negedge clk);
            if (m_done_o) begin
                t1 = cyc;
                break;
            end
            if (!pulsed && m_s_stb_o && (m_s_adr_o == M_SRC + 19'd100)) begin
                m_start = 1'b1;
                pulsed = 1'b1;
            end else begin
                m_start = 1'b0;
            end
        end
        m_start = 1'b0;
        chk("copy1_cycles", 32'(t1 - t0), 32'(CPW * M_WORDS));
        chk("copy1_hold_at_done", 32'({m_cpu_hold_o, m_busy_o}), 32'(0));
        chk("copy1_ram", 32'(ram_bad()), 32'(0));
        chk("copy1_writes", 32'(m_wr_cnt), 32'(M_WORDS));
`ifdef BOOTSHADOW_VERIFY_EN
        chk("copy1_verify_err", 32'(m_verify_err_o), 32'(0));
`endif

        // Small instance: no auto start; WORDS=1 with address wrap bases
        chk("w_no_autostart", 32'({w_s_cyc_o, w_s_stb_o, w_d_stb_o, w_busy_o, w_done_o, w_cpu_hold_o}), 32'b000001);
        @(negedge clk) w_start = 1'b1;
        @(negedge clk) w_start = 1'b0;
        chk("w_rd_cycle", 32'({w_s_cyc_o, w_s_stb_o, w_s_we_o, w_d_stb_o}), 32'b1100);
        chk("w_rd_adr", 32'(w_s_adr_o), 32'h7FFFF);
        @(negedge clk);
        chk("w_wr_cycle", 32'({w_s_stb_o, w_d_cyc_o, w_d_stb_o, w_d_we_o}), 32'b0111);
        chk("w_wr_adr", 32'(w_d_adr_o), 32'(0));
        chk("w_wr_dat", 32'(w_d_dat_o), 32'h5A5A);
        repeat (CPW - 1) @(negedge clk);
        chk("w_done", 32'({w_done_o, w_cpu_hold_o, w_busy_o}), 32'b100);
`ifdef BOOTSHADOW_VERIFY_EN
        chk("w_verify_err", 32'(w_verify_err_o), 32'(0));
`endif

        // Copy 2: re-copy from DONE with random 0-5 wait states
        ram.delete(); m_wr_cnt = 0; max_wait = 5; corrupt_en = 1'b1;
        pulse_start();
        chk("copy2_restart", 32'({m_busy_o, m_done_o, m_cpu_hold_o, m_s_stb_o}), 32'b1011);
        chk("copy2_restart_adr", 32'(m_s_adr_o), 32'(M_SRC));
        run_to_done(M_WORDS * CPW * 7 + 100, took);
        chk("copy2_done", 32'(took != -1), 32'(1));
        chk("copy2_writes", 32'(m_wr_cnt), 32'(M_WORDS));
        chk("copy2_ram", 32'(ram_bad()), 32'(0));
`ifdef BOOTSHADOW_VERIFY_EN
        chk("copy2_verify_err", 32'(m_verify_err_o), 32'(1));
`endif

        // Copy 3: reset at word 37, copy restarts from word 0
        ram.delete(); m_wr_cnt = 0; max_wait = 2; corrupt_en = 1'b0;
        pulse_start();
`ifdef BOOTSHADOW_VERIFY_EN
        chk("copy3_start_clears_err", 32'(m_verify_err_o), 32'(0));
`endif
        found = 1'b0;
        for (int k = 0; k < M_WORDS * CPW * 4; k++) begin
            @(negedge clk);
            if (m_d_stb_o && m_d_we_o && (m_d_adr_o == M_DST + 19'd37)) begin
                found = 1'b1;
                break;
            end
        end
        chk("copy3_reached_word37", 32'(found), 32'(1));
        #2 rst = 1'b0;
        #1;
        chk("copy3_async_strobes", 32'({m_s_cyc_o, m_s_stb_o, m_d_cyc_o, m_d_stb_o, m_d_we_o, m_busy_o}), 32'(0));
        chk("copy3_async_hold", 32'(m_cpu_hold_o), 32'(1));
        repeat (3) @(negedge clk);
        ram.delete(); m_wr_cnt = 0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("copy3_restart_word0", 32'({m_s_stb_o, m_s_adr_o}), 32'({1'b1, M_SRC}));
        run_to_done(M_WORDS * CPW * 4 + 100, took);
        chk("copy3_done", 32'(took != -1), 32'(1));
        chk("copy3_writes", 32'(m_wr_cnt), 32'(M_WORDS));
        chk("copy3_ram", 32'(ram_bad()), 32'(0));
`ifdef BOOTSHADOW_VERIFY_EN
        chk("copy3_verify_err", 32'(m_verify_err_o), 32'(0));
`endif

        // Protocol monitors over the whole run
        chk("stb_dropped_before_ack", 32'(stb_viol), 32'(0));
        chk("both_stb_high", 32'(both_viol), 32'(0));
        chk("hold_vs_done", 32'(hold_bad), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bootrom_shadow.md
Name: bootrom_shadow

Overview:
- Boot-time sequencer that copies the BIOS image, one 16-bit word at a time, from the boot ROM into shadow RAM.
- It has two Wishbone master ports: a read-only source port to the ROM and a write-only destination port to RAM.
- It holds the CPU in reset-hold (cpu_hold_o) until the copy completes, then releases it.
- It sits between the reset logic and the Zet core, alongside the ROM and RAM slaves, ahead of the main bus mux.

Parameters:
- SRC_BASE, 19'h7FF00: word address (adr[19:1]) of ROM word 0.
- DST_BASE, 19'h7FF00: word address of the shadow RAM destination.
- WORDS, 256: number of 16-bit words to copy; legal range 1..65536.
- AUTO_START, 1: when 1, the copy begins on the first clock after reset deassertion; when 0, it waits for start_i.

Ports:
- clk in 1: system clock.
- rst in 1: asynchronous, active-low reset.
- start_i in 1: one-cycle pulse requesting a (re)copy; honoured only in IDLE or DONE.
- busy_o out 1: high while in RD or WR.
- done_o out 1: high in DONE.
- cpu_hold_o out 1: high from reset until DONE is reached.
- s_adr_o out 19 [19:1]: source address.
- s_dat_i in 16: source read data.
- s_cyc_o, s_stb_o out 1 each: source cycle and strobe.
- s_we_o out 1: tied to 0.
- s_sel_o out 2: tied to 2'b11.
- s_ack_i in 1: source acknowledge.
- d_adr_o out 19 [19:1]: destination address.
- d_dat_o out 16: destination write data.
- d_cyc_o, d_stb_o out 1 each: destination cycle and strobe.
- d_we_o out 1: destination write enable.
- d_sel_o out 2: tied to 2'b11.
- d_ack_i in 1: destination acknowledge.

Behaviour:
- Reset values (rst low): state=IDLE, cnt=0, data latch=0, all cyc/stb/we=0, busy_o=0, done_o=0, cpu_hold_o=1; adr outputs = base addresses.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - Go to RD if AUTO_START=1 and this is the first cycle after reset.
  - Otherwise go to RD when start_i=1.
- RD:
  - s_cyc_o = s_stb_o = 1; s_adr_o = SRC_BASE + cnt.
  - On a clock edge with s_ack_i=1: latch s_dat_i, go to WR.
  - Strobe remains asserted until ack (wait states unlimited).
- WR:
  - d_cyc_o = d_stb_o = d_we_o = 1; d_adr_o = DST_BASE + cnt; d_dat_o = latched word.
  - On an edge with d_ack_i=1: if cnt==WORDS-1 go to DONE; else cnt++ and go to RD.
- DONE:
  - done_o=1, cpu_hold_o=0, all strobes 0.
  - start_i=1 clears cnt, sets cpu_hold_o=1, and goes to RD.
- Slaves may ack combinationally in the same cycle as stb (the ROM does). Zero-wait copy takes exactly 2*WORDS cycles from first RD cycle to DONE entry.
- Only one master port is active at a time; cyc and stb drop in the cycle after ack.
- Addresses are WORDS-bounded: base+cnt is 19-bit modulo arithmetic, and wrap above 19'h7FFFF is permitted silently.
- cnt width is $clog2(WORDS)+1 bits.
- start_i while busy is ignored (no restart, no error).
- Ack received outside the owning state is ignored.
- rst low mid-copy: all strobes drop asynchronously and the copy restarts from word 0 after release (per AUTO_START). A partial destination write is not retried.
- WORDS=1: RD, WR, DONE, taking 2 cycles.

Optional Feature:
- BOOTSHADOW_VERIFY_EN defined:
  - Adds states VRD (destination read, we=0) and VCMP after each WR.
  - The read-back word is compared with the latched word.
  - On mismatch: sticky verify_err_o=1. The copy still proceeds.
  - Zero-wait copy takes 4*WORDS cycles.
  - Port verify_err_o (out 1) exists only with the macro; it is reset to 0 and cleared on start_i.
- Undefined: no verify states, no verify_err_o port, write-only destination.

Decomposition:
- Package bootrom_shadow_pkg: state encoding constants (IDLE=0, RD=1, WR=2, DONE=3, VRD=4, VCMP=5), default SRC_BASE/DST_BASE/WORDS.
- One sub-module: wb_master_port (single-beat cyc/stb/ack handler, instantiated twice for source and destination).

Test Plan:
- AUTO_START=1, WORDS=256, zero-wait ROM holding word=addr^16'hA5A5:
  - RAM holds identical 256 words.
  - done_o rises at cycle 512 after the first RD cycle; cpu_hold_o falls in the same cycle.
- Random 0-5 wait states on both slaves:
  - Every RAM word matches the ROM.
  - stb never drops before ack.
  - s_stb_o and d_stb_o are never high together.
- start_i pulsed at word 100 of a copy: ignored; after DONE, start_i pulse re-copies all 256 words with cpu_hold_o=1 throughout.
- rst low at word 37 for 3 cycles: strobes low within the reset cycle; copy restarts at word 0; done only after a full 256 words.
- WORDS=1, SRC_BASE=19'h7FFFF, DST_BASE=19'h00000: one read at 7FFFF, one write at 00000, DONE after 2 cycles.
- With BOOTSHADOW_VERIFY_EN, RAM model corrupting word 5 read-back: verify_err_o=1 after word 5, copy still reaches DONE at 4*WORDS cycles.
